fifo_tx_serializer: RTL
=======================

FIFO_TX_SERIALIZER -- requirements
Module: fifo_tx_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..255.
REQ-002 Parameter PARITY_EN, default 1: 1 = even parity bit sent after data; 0 = no parity bit.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  8  byte from upstream FIFO data_out; valid the cycle after en_read is asserted.
REQ-006 fifo_empty  input  1  high when upstream FIFO holds no data.
REQ-007 underflow  input  1  upstream FIFO underflow flag; sampled only in FETCH.
REQ-008 tx_en  input  1  permission to start a new frame.
REQ-009 en_read  output  1  one-cycle read strobe to upstream FIFO.
REQ-010 tx  output  1  serial line; idle level 1.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 frame_err  output  1  sticky; set on underflow in FETCH; cleared only by reset.

Function
REQ-013 FSM states: IDLE, READ, FETCH, START, DATA, PARITY, STOP.
REQ-014 IDLE -> READ when tx_en=1 and fifo_empty=0; otherwise remain in IDLE.
REQ-015 en_read=1 only while in READ, for exactly one cycle per frame; READ -> FETCH unconditionally.
REQ-016 FETCH: data_in captured into an 8-bit shift register at the end of the cycle; if underflow=1 in FETCH, frame_err set, nothing transmitted, next state IDLE; else next state START.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles.
REQ-018 DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles; 3-bit bit counter, 8-bit baud counter.
REQ-019 PARITY (only when PARITY_EN=1): tx = XOR of the 8 captured bits (even parity) for CLKS_PER_BIT cycles; when PARITY_EN=0, DATA -> STOP directly.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-021 tx=1 in IDLE, READ, FETCH and STOP.
REQ-022 tx_en deasserted mid-frame: current frame completes; no new frame starts.
REQ-023 fifo_empty changes after READ have no effect on the current frame.
REQ-024 Back-to-back with PARITY_EN=1, CLKS_PER_BIT=4, FIFO non-empty: en_read pulses exactly 47 cycles apart (READ 1 + FETCH 1 + 44 frame + IDLE 1).
REQ-025 tx is registered (no combinational glitches); en_read is decoded from the state register.

Reset
REQ-026 On reset assertion, immediately and asynchronously: state=IDLE, tx=1, en_read=0, busy=0, frame_err=0, shift register, bit and baud counters all 0.
REQ-027 Reset mid-frame aborts the frame; after release, no partial frame is resumed; the next frame starts from IDLE with a new read.
REQ-028 Normal operation resumes on the first rising clk edge after reset deasserts.

Verification
REQ-029 fifo_empty=0, tx_en=1, data_in=0xA5 after read -> tx bits 0 | 1,0,1,0,0,1,0,1 | 0 | 1, each 4 cycles; en_read exactly one cycle; busy high from READ through STOP.
REQ-030 data_in=0x07, PARITY_EN=1 -> parity bit 1; rerun with PARITY_EN=0 -> STOP immediately follows bit 7, frame 40 cycles.
REQ-031 fifo_empty=1 held 100 cycles with tx_en=1 -> en_read never asserted; tx=1; busy=0.
REQ-032 underflow=1 during FETCH -> frame_err=1 and stays 1; tx never leaves 1; FSM returns to IDLE; next good byte transmits normally with frame_err still 1.
REQ-033 reset pulsed in the middle of DATA bit 3 -> tx=1 and busy=0 without waiting for clk; frame_err=0; after release, the next frame reads a new byte.
REQ-034 15 random bytes streamed back-to-back (tx_en=1, fifo_empty=0) -> 15 en_read pulses 47 cycles apart; the decoded serial stream matches the bytes in order with correct parity.

Source files
------------

// File: rtl/fifo_tx_serializer.sv
// Reads one byte per frame from an upstream FIFO and shifts it out as
// start / 8 data bits (LSB first) / optional even parity / stop.
module fifo_tx_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       fifo_empty,
  input  logic       underflow,
  input  logic       tx_en,
  output logic       en_read,
  output logic       tx,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] baud_q, baud_d;
  logic       tx_q, tx_d;
  logic       frame_err_q, frame_err_d;
  logic       baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bit_cnt_d   = bit_cnt_q;
    baud_d      = baud_q;
    frame_err_d = frame_err_q;
    case (state_q)
      S_IDLE:  if (tx_en && !fifo_empty) state_d = S_READ;
      S_READ:  state_d = S_FETCH;
      S_FETCH: begin
        if (underflow) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          shift_d   = data_in;
          parity_d  = ^data_in;
          baud_d    = '0;
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        baud_d = baud_q + 8'd1;
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        baud_d = baud_q + 8'd1;
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        baud_d = baud_q + 8'd1;
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        baud_d = baud_q + 8'd1;
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is decoded from the next state so the registered tx lines up
  // with the state it belongs to.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_cnt_q   <= '0;
      baud_q      <= '0;
      tx_q        <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bit_cnt_q   <= bit_cnt_d;
      baud_q      <= baud_d;
      tx_q        <= tx_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign en_read   = (state_q == S_READ);
  assign busy      = (state_q != S_IDLE);
  assign tx        = tx_q;
  assign frame_err = frame_err_q;

endmodule
